// File: rtl/sdram_read.sv
// SDRAM read engine: fetches 32-bit words as burst-of-2 reads from a 16-bit SDRAM
// and pushes each assembled word into the read FIFO. Also services auto-refresh.
module sdram_read #(
    parameter int unsigned T_RCD   = 3,
    parameter int unsigned T_RP    = 3,
    parameter int unsigned T_RFC   = 10,
    parameter int unsigned CAS_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic [2:0]  command,
    output logic [11:0] addr,
    output logic [1:0]  bank,
    input  logic [15:0] data_in,
    input  logic        en,
    output logic        ready,
    input  logic [21:0] address,
    input  logic        auto_refresh,
    output logic [31:0] fifo_data,
    input  logic        fifo_full,
    output logic        fifo_wr
);

    // SDRAM_CMD_* encodings as {RAS_n, CAS_n, WE_n}
    localparam logic [2:0] CmdNop  = 3'b111;
    localparam logic [2:0] CmdAct  = 3'b011;
    localparam logic [2:0] CmdRead = 3'b101;
    localparam logic [2:0] CmdPre  = 3'b010;
    localparam logic [2:0] CmdAr   = 3'b001;

    localparam logic [7:0] RcdDly  = 8'(T_RCD - 1);
    localparam logic [7:0] RpDly   = 8'(T_RP - 1);
    localparam logic [7:0] RfcDly  = 8'(T_RFC - 1);
    localparam logic [1:0] CasInit = 2'(CAS_LAT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StActive,
        StReadCmd,
        StCasWait,
        StReadTop,
        StReadBottom,
        StPrecharge,
        StNext
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  delay_q, delay_d;
    logic [1:0]  cas_q, cas_d;
    logic        refresh_q, refresh_d;
    logic [21:0] address_q, address_d;
    logic [15:0] top_q, top_d;
    logic [2:0]  command_q, command_d;
    logic [11:0] addr_q, addr_d;
    logic [1:0]  bank_q, bank_d;
    logic [31:0] fifo_data_q, fifo_data_d;
    logic        fifo_wr_q, fifo_wr_d;

    always_comb begin
        state_d     = state_q;
        delay_d     = delay_q;
        cas_d       = cas_q;
        refresh_d   = refresh_q;
        address_d   = address_q;
        top_d       = top_q;
        command_d   = CmdNop;
        addr_d      = addr_q;
        bank_d      = bank_q;
        fifo_data_d = fifo_data_q;
        fifo_wr_d   = 1'b0;

        if (delay_q != 8'd0) begin
            delay_d = delay_q - 8'd1;
        end else begin
            case (state_q)
                StIdle: begin
                    if (en && !fifo_full) begin
                        address_d = address;
                        state_d   = StActive;
                    end else if (refresh_q) begin
                        command_d = CmdAr;
                        delay_d   = RfcDly;
                        refresh_d = 1'b0;
                    end
                end
                StActive: begin
                    command_d = CmdAct;
                    addr_d    = address_q[19:8];
                    bank_d    = address_q[21:20];
                    delay_d   = RcdDly;
                    state_d   = StReadCmd;
                end
                StReadCmd: begin
                    command_d = CmdRead;
                    addr_d    = {4'b0000, address_q[7:0]};
                    address_d = address_q + 22'd2;
                    cas_d     = CasInit;
                    state_d   = StCasWait;
                end
                StCasWait: begin
                    // Leave one edge early so READ_TOP samples exactly CAS_LAT after READ
                    cas_d = cas_q - 2'd1;
                    if (cas_q <= 2'd1) begin
                        state_d = StReadTop;
                    end
                end
                StReadTop: begin
                    top_d   = data_in;
                    state_d = StReadBottom;
                end
                StReadBottom: begin
                    fifo_data_d = {top_q, data_in};
                    fifo_wr_d   = 1'b1;
                    state_d     = StPrecharge;
                end
                StPrecharge: begin
                    command_d = CmdPre;
                    addr_d    = 12'h400;
                    delay_d   = RpDly;
                    state_d   = StNext;
                end
                StNext: begin
                    if (refresh_q) begin
                        command_d = CmdAr;
                        delay_d   = RfcDly;
                        refresh_d = 1'b0;
                    end else if (en && !fifo_full) begin
                        // Activate directly so back-to-back bursts keep their period
                        command_d = CmdAct;
                        addr_d    = address_q[19:8];
                        bank_d    = address_q[21:20];
                        delay_d   = RcdDly;
                        state_d   = StReadCmd;
                    end else if (!en) begin
                        state_d = StIdle;
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end

        if (auto_refresh && en) begin
            refresh_d = 1'b1;
        end
    end

    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            delay_q     <= 8'd0;
            cas_q       <= 2'd0;
            refresh_q   <= 1'b0;
            address_q   <= 22'd0;
            top_q       <= 16'd0;
            command_q   <= CmdNop;
            addr_q      <= 12'd0;
            bank_q      <= 2'd0;
            fifo_data_q <= 32'd0;
            fifo_wr_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            delay_q     <= delay_d;
            cas_q       <= cas_d;
            refresh_q   <= refresh_d;
            address_q   <= address_d;
            top_q       <= top_d;
            command_q   <= command_d;
            addr_q      <= addr_d;
            bank_q      <= bank_d;
            fifo_data_q <= fifo_data_d;
            fifo_wr_q   <= fifo_wr_d;
        end
    end

    assign command   = command_q;
    assign addr      = addr_q;
    assign bank      = bank_q;
    assign fifo_data = fifo_data_q;
    assign fifo_wr   = fifo_wr_q;
    assign ready     = (delay_q == 8'd0) && (state_q == StIdle);

endmodule

// File: tb/tb_sdram_read.sv
// Bench for sdram_read: an SDRAM data model plus scoreboards for commands and FIFO writes.
module tb_sdram_read;

    localparam logic [2:0] CmdNop  = 3'b111;
    localparam logic [2:0] CmdAct  = 3'b011;
    localparam logic [2:0] CmdRead = 3'b101;
    localparam logic [2:0] CmdPre  = 3'b010;
    localparam logic [2:0] CmdAr   = 3'b001;
    localparam int CasLat = 2;

    logic        clk;
    logic        rst;
    logic [2:0]  command;
    logic [11:0] addr;
    logic [1:0]  bank;
    logic [15:0] data_in;
    logic        en;
    logic        ready;
    logic [21:0] address;
    logic        auto_refresh;
    logic [31:0] fifo_data;
    logic        fifo_full;
    logic        fifo_wr;

    sdram_read dut (
        .clk          (clk),
        .rst          (rst),
        .command      (command),
        .addr         (addr),
        .bank         (bank),
        .data_in      (data_in),
        .en           (en),
        .ready        (ready),
        .address      (address),
        .auto_refresh (auto_refresh),
        .fifo_data    (fifo_data),
        .fifo_full    (fifo_full),
        .fifo_wr      (fifo_wr)
    );

    typedef struct {
        logic [2:0]  cmd;
        logic [11:0] addr;
        logic [11:0] mask;
        logic [1:0]  bank;
        bit          bank_chk;
        int          at;
    } cmd_t;

    typedef struct {
        logic [31:0] data;
        int          at;
    } wr_t;

    cmd_t exp_cmd[$];
    wr_t  exp_wr[$];
    logic [15:0] mem [logic [21:0]];

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int rd_at = -100;
    logic [21:0] rd_key = 22'd0;
    logic [11:0] model_row = 12'd0;
    logic [1:0]  model_bank = 2'd0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] mem_rd(logic [21:0] k);
        if (mem.exists(k)) return mem[k];
        return 16'hBAD0;
    endfunction

    // SDRAM data model: drive beats so they are stable at the sampling (falling) edge
    initial data_in = 16'h0000;
    always @(posedge clk) begin
        if (cyc + 1 == rd_at + CasLat) data_in = mem_rd(rd_key);
        else if (cyc + 1 == rd_at + CasLat + 1) data_in = mem_rd(rd_key + 22'd1);
        else data_in = 16'hDEAD;
    end

    // Monitor: sample 1ns after each falling edge; cyc is the edge number
    always @(negedge clk) begin
        cmd_t e;
        wr_t  w;
        #1;
        cyc++;
        if (command != CmdNop) begin
            n_vec++;
            if (exp_cmd.size() == 0) begin
                n_err++;
                $display("FAIL cmd_unexpected: got cmd=%b addr=%h bank=%0d at edge %0d, required none",
                         command, addr, bank, cyc);
            end else begin
                e = exp_cmd.pop_front();
                if (command !== e.cmd || (addr & e.mask) !== (e.addr & e.mask) ||
                    (e.bank_chk && bank !== e.bank) || cyc != e.at) begin
                    n_err++;
                    $display("FAIL cmd: got cmd=%b addr=%h bank=%0d edge %0d, required cmd=%b addr=%h/%h bank=%0d edge %0d",
                             command, addr, bank, cyc, e.cmd, e.addr, e.mask, e.bank, e.at);
                end
            end
            if (command == CmdAct) begin
                model_row  = addr;
                model_bank = bank;
            end
            if (command == CmdRead) begin
                rd_at  = cyc;
                rd_key = {model_bank, model_row, addr[7:0]};
            end
        end
        if (fifo_wr) begin
            n_vec++;
            if (exp_wr.size() == 0) begin
                n_err++;
                $display("FAIL wr_unexpected: got data=%h at edge %0d, required none", fifo_data, cyc);
            end else begin
                w = exp_wr.pop_front();
                if (fifo_data !== w.data || cyc != w.at) begin
                    n_err++;
                    $display("FAIL wr: got data=%h edge %0d, required data=%h edge %0d",
                             fifo_data, cyc, w.data, w.at);
                end
            end
        end
    end

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, got, exp);
        end
    endtask

    task automatic wait_cyc(int k);
        while (cyc < k) @(posedge clk);
    endtask

    task automatic push_cmd(logic [2:0] c, logic [11:0] a, logic [11:0] m, logic [1:0] b,
                            bit bc, int at);
        cmd_t e;
        e.cmd = c; e.addr = a; e.mask = m; e.bank = b; e.bank_chk = bc; e.at = at;
        exp_cmd.push_back(e);
    endtask

    // ACT at b, READ at b+3, fifo_wr at b+6, PRE at b+7 for the default timing
    task automatic push_burst(int b, logic [11:0] row, logic [7:0] col, logic [31:0] word);
        wr_t w;
        push_cmd(CmdAct, row, 12'hFFF, 2'd0, 1'b1, b);
        push_cmd(CmdRead, {4'b0000, col}, 12'hFFF, 2'd0, 1'b0, b + 3);
        w.data = word; w.at = b + 6;
        exp_wr.push_back(w);
        push_cmd(CmdPre, 12'h400, 12'h400, 2'd0, 1'b0, b + 7);
    endtask

    logic [7:0]  t2_col  [4] = '{8'hFC, 8'hFE, 8'h00, 8'h02};
    logic [31:0] t2_word [4] = '{32'hAAAA0001, 32'hBBBB0002, 32'hCCCC0003, 32'hDDDD0004};

    initial begin
        int b;
        int n;
        rst = 1'b1; en = 1'b0; address = 22'd0; auto_refresh = 1'b0; fifo_full = 1'b0;
        mem[22'h000010] = 16'h1234; mem[22'h000011] = 16'h5678;
        mem[22'h0000FC] = 16'hAAAA; mem[22'h0000FD] = 16'h0001;
        mem[22'h0000FE] = 16'hBBBB; mem[22'h0000FF] = 16'h0002;
        mem[22'h000100] = 16'hCCCC; mem[22'h000101] = 16'h0003;
        mem[22'h000102] = 16'hDDDD; mem[22'h000103] = 16'h0004;
        mem[22'h000200] = 16'h1111; mem[22'h000201] = 16'h2222;
        mem[22'h000202] = 16'h3333; mem[22'h000203] = 16'h4444;
        mem[22'h000300] = 16'h5555; mem[22'h000301] = 16'h6666;
        mem[22'h000302] = 16'h7777; mem[22'h000303] = 16'h8888;
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        chk("rst_command", 32'(command), 32'(CmdNop));
        chk("rst_addr", 32'(addr), 32'd0);
        chk("rst_bank", 32'(bank), 32'd0);
        chk("rst_fifo_data", fifo_data, 32'd0);
        chk("rst_fifo_wr", 32'(fifo_wr), 32'd0);
        chk("rst_ready", 32'(ready), 32'd1);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        chk("post_rst_ready", 32'(ready), 32'd1);

        // Single burst from 0x000010, en dropped mid-burst
        @(posedge clk);
        en = 1'b1; address = 22'h000010; b = cyc + 2;
        push_burst(b, 12'h000, 8'h10, 32'h12345678);
        wait_cyc(b - 1);
        chk("t1_ready_drop", 32'(ready), 32'd0);
        en = 1'b0;
        wait_cyc(b + 11);
        chk("t1_idle_ready", 32'(ready), 32'd1);

        // Four back-to-back bursts crossing column 0xFE -> row 1
        @(posedge clk);
        en = 1'b1; address = 22'h0000FC; b = cyc + 2;
        for (int i = 0; i < 4; i++) begin
            push_burst(b + 10 * i, (i < 2) ? 12'h000 : 12'h001, t2_col[i], t2_word[i]);
        end
        wait_cyc(b + 32);
        en = 1'b0;
        wait_cyc(b + 41);
        chk("t2_idle_ready", 32'(ready), 32'd1);

        // FIFO full across PRE, held 20 cycles
        @(posedge clk);
        en = 1'b1; address = 22'h000200; b = cyc + 2;
        push_burst(b, 12'h002, 8'h00, 32'h11112222);
        push_burst(b + 27, 12'h002, 8'h02, 32'h33334444);
        wait_cyc(b + 6);
        fifo_full = 1'b1;
        wait_cyc(b + 15);
        chk("t3_hold_not_ready", 32'(ready), 32'd0);
        wait_cyc(b + 26);
        fifo_full = 1'b0;
        wait_cyc(b + 29);
        en = 1'b0;
        wait_cyc(b + 38);
        chk("t3_idle_ready", 32'(ready), 32'd1);

        // Refresh request mid-burst: AR after PRE, then ACT after T_RFC
        @(posedge clk);
        en = 1'b1; address = 22'h000300; b = cyc + 2;
        push_burst(b, 12'h003, 8'h00, 32'h55556666);
        push_cmd(CmdAr, 12'h000, 12'h000, 2'd0, 1'b0, b + 10);
        push_burst(b + 20, 12'h003, 8'h02, 32'h77778888);
        wait_cyc(b + 4);
        auto_refresh = 1'b1;
        @(posedge clk);
        auto_refresh = 1'b0;
        wait_cyc(b + 22);
        en = 1'b0;
        wait_cyc(b + 31);
        chk("t4_idle_ready", 32'(ready), 32'd1);

        // Refresh with en=0 is ignored; with en=1 and FIFO full it runs from IDLE
        @(posedge clk);
        auto_refresh = 1'b1;
        @(posedge clk);
        auto_refresh = 1'b0;
        repeat (15) @(posedge clk);
        chk("t5_ignored_ready", 32'(ready), 32'd1);
        en = 1'b1; fifo_full = 1'b1; auto_refresh = 1'b1; n = cyc;
        push_cmd(CmdAr, 12'h000, 12'h000, 2'd0, 1'b0, n + 2);
        @(posedge clk);
        auto_refresh = 1'b0;
        for (int k = n + 2; k <= n + 10; k++) begin
            wait_cyc(k);
            chk("t5_ar_ready_low", 32'(ready), 32'd0);
        end
        wait_cyc(n + 11);
        chk("t5_ar_ready_back", 32'(ready), 32'd1);
        en = 1'b0; fifo_full = 1'b0;
        repeat (3) @(posedge clk);

        // Reset during CAS_WAIT aborts the burst
        @(posedge clk);
        en = 1'b1; address = 22'h000400; b = cyc + 2;
        push_cmd(CmdAct, 12'h004, 12'hFFF, 2'd0, 1'b1, b);
        push_cmd(CmdRead, 12'h000, 12'hFFF, 2'd0, 1'b0, b + 3);
        wait_cyc(b + 3);
        rst = 1'b0;
        #1;
        chk("t6_rst_command", 32'(command), 32'(CmdNop));
        chk("t6_rst_fifo_wr", 32'(fifo_wr), 32'd0);
        chk("t6_rst_ready", 32'(ready), 32'd1);
        chk("t6_rst_addr", 32'(addr), 32'd0);
        chk("t6_rst_fifo_data", fifo_data, 32'd0);
        en = 1'b0;
        repeat (2) @(posedge clk);
        rst = 1'b1;
        repeat (20) @(posedge clk);
        chk("t6_release_ready", 32'(ready), 32'd1);

        chk("cmd_queue_drained", 32'(exp_cmd.size()), 32'd0);
        chk("wr_queue_drained", 32'(exp_wr.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
